// File: rtl/nibble_accum_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : nibble_accum_pkg                                        |
// | Purpose  : Shared state encoding and nibble width for the          |
// |            nibble_sum_accum frame accumulator.                     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package nibble_accum_pkg;

  // Width of one upstream adder result.
  localparam int NIB_W = 4;

  // Width of the per-frame sample counter (holds up to 15).
  localparam int CNT_W = 4;

  // Frame accumulator controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage : nibble_accum_pkg
`default_nettype wire

// File: rtl/nibble_sum_accum_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : sat_add                                                 |
// | Purpose  : Unsigned ACC_W-bit adder that clamps at 2^ACC_W-1 and   |
// |            reports when the clamp was applied.                     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module sat_add #(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // One extra bit catches the carry out; a carry means the true sum
  // does not fit and the result must be pinned to all ones.
  logic [ACC_W:0] w_wide;

  assign w_wide = {1'b0, a} + {1'b0, b};
  assign sat    = w_wide[ACC_W];
  assign sum    = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];

endmodule : sat_add
`default_nettype wire

// File: rtl/nibble_sum_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : nibble_sum_accum                                        |
// | Purpose  : Accumulates a frame of 4-bit adder results into a       |
// |            saturating total, counts the samples, and presents the  |
// |            frame result with a valid/ready handshake.              |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module nibble_sum_accum
  import nibble_accum_pkg::*;
#(
  parameter int ACC_W   = 8,
  parameter int MAX_CNT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  input  logic [NIB_W-1:0] in_sum,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  // State codes taken from the shared enum so the encoding lives in one place.
  localparam logic [1:0] c_S_IDLE  = IDLE;
  localparam logic [1:0] c_S_ACCUM = ACCUM;
  localparam logic [1:0] c_S_DONE  = DONE;

  localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_CNT);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_out_valid;

  logic [ACC_W-1:0] w_sample;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_xfer;
  logic             w_out_hs;
  logic             w_first_closes;
  logic             w_accum_closes;

  // Upstream sample widened to accumulator width.
  assign w_sample = {{(ACC_W - NIB_W){1'b0}}, in_sum};

  // Saturating running total for samples after the first.
  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a   (r_acc),
    .b   (w_sample),
    .sum (w_sum),
    .sat (w_sat)
  );

  // Handshake qualifiers; ena gates both sides so nothing moves while frozen.
  assign in_ready  = ena && (r_state != c_S_DONE);
  assign w_xfer    = in_valid && in_ready;
  assign w_out_hs  = ena && out_ready && (r_state == c_S_DONE);
  assign w_cnt_inc = r_count + c_CNT_ONE;

  // Frame close conditions: explicit last marker or the sample cap.
  assign w_first_closes = in_last || (c_MAX_CNT == c_CNT_ONE);
  assign w_accum_closes = in_last || (w_cnt_inc == c_MAX_CNT);

  // Frame state machine and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        c_S_IDLE: begin
          if (w_xfer) begin
            r_acc   <= w_sample;
            r_count <= c_CNT_ONE;
            r_ovf   <= 1'b0;
            if (w_first_closes) begin
              r_state     <= c_S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= c_S_ACCUM;
            end
          end
        end
        c_S_ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_sum;
            r_count <= w_cnt_inc;
            r_ovf   <= r_ovf | w_sat;
            if (w_accum_closes) begin
              r_state     <= c_S_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        c_S_DONE: begin
          if (w_out_hs) begin
            r_state     <= c_S_IDLE;
            r_acc       <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= c_S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign acc       = r_acc;
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign out_valid = r_out_valid;

endmodule : nibble_sum_accum
`default_nettype wire

// File: tb/tb_nibble_sum_accum.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_nibble_sum_accum                                     |
// | Purpose  : Directed self-checking bench for nibble_sum_accum with  |
// |            the default width and a 5-bit accumulator instance.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_nibble_sum_accum;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic [3:0] in_sum;
  logic       in_last;
  logic       out_ready;

  logic       in_ready8, ovf8, out_valid8;
  logic [7:0] acc8;
  logic [3:0] count8;

  logic       in_ready5, ovf5, out_valid5;
  logic [4:0] acc5;
  logic [3:0] count5;

  int n_checks = 0;
  int n_pass   = 0;

  nibble_sum_accum dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .in_ready  (in_ready8),
    .acc       (acc8),
    .count     (count8),
    .ovf       (ovf8),
    .out_valid (out_valid8),
    .out_ready (out_ready)
  );

  nibble_sum_accum #(.ACC_W(5), .MAX_CNT(15)) dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .in_last   (in_last),
    .in_ready  (in_ready5),
    .acc       (acc5),
    .count     (count5),
    .ovf       (ovf5),
    .out_valid (out_valid5),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] s;
    logic       last;
    logic       ordy;
    logic       en;
    logic [7:0] e_acc;
    logic [3:0] e_cnt;
    logic       e_ovf;
    logic       e_ov;
    logic       e_ir;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] s, input logic last,
                       input logic ordy, input logic en);
    in_valid  = v;
    in_sum    = s;
    in_last   = last;
    out_ready = ordy;
    ena       = en;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic [7:0] a, input logic [3:0] c,
                        input logic o, input logic ov, input logic ir);
    check({tag, ".acc"},       32'(acc8),       32'(a));
    check({tag, ".count"},     32'(count8),     32'(c));
    check({tag, ".ovf"},       32'(ovf8),       32'(o));
    check({tag, ".out_valid"}, 32'(out_valid8), 32'(ov));
    check({tag, ".in_ready"},  32'(in_ready8),  32'(ir));
  endtask

  initial begin
    //          v  s   last ordy en   acc cnt ovf ov ir
    vecs[0] = '{1, 3,  0,   0,   1,   3,  1,  0,  0, 1};
    vecs[1] = '{1, 5,  0,   0,   1,   8,  2,  0,  0, 1};
    vecs[2] = '{1, 7,  1,   0,   1,   15, 3,  0,  1, 0};
    vecs[3] = '{0, 0,  0,   1,   1,   0,  0,  0,  0, 1};
    vecs[4] = '{1, 15, 0,   0,   1,   15, 1,  0,  0, 1};
    vecs[5] = '{1, 1,  0,   0,   1,   16, 2,  0,  0, 1};
    vecs[6] = '{0, 0,  0,   0,   1,   16, 2,  0,  0, 1};
    vecs[7] = '{0, 9,  1,   0,   1,   16, 2,  0,  0, 1};
    vecs[8] = '{1, 0,  1,   0,   1,   16, 3,  0,  1, 0};
    vecs[9] = '{0, 0,  0,   1,   1,   0,  0,  0,  0, 1};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1);
    #12;
    check8("reset", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick();

    // Frame 3,5,7 then a frame 15,1 with bubbles and an ignored last.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].v, vecs[i].s, vecs[i].last, vecs[i].ordy, vecs[i].en);
      tick();
      check8($sformatf("vec%0d", i), vecs[i].e_acc, vecs[i].e_cnt,
             vecs[i].e_ovf, vecs[i].e_ov, vecs[i].e_ir);
    end

    // Fifteen samples of 15 with no last: the count cap closes the frame.
    for (int k = 1; k <= 15; k++) begin
      drive(1, 15, 0, 0, 1);
      tick();
      if (k == 15) check8("cap15", 8'd225, 4'd15, 1'b0, 1'b1, 1'b0);
      else         check8($sformatf("cap%0d", k), 8'(15 * k), 4'(k), 1'b0, 1'b0, 1'b1);
    end
    drive(0, 0, 0, 1, 1);
    tick();
    check8("cap_hs", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Saturation in the 5-bit instance; the 8-bit one absorbs the same total.
    drive(1, 15, 0, 0, 1); tick();
    drive(1, 15, 0, 0, 1); tick();
    check("sat5.acc_mid", 32'(acc5), 32'd30);
    check("sat5.ovf_mid", 32'(ovf5), 32'd0);
    drive(1, 4, 1, 0, 1); tick();
    check("sat5.acc",       32'(acc5),       32'd31);
    check("sat5.ovf",       32'(ovf5),       32'd1);
    check("sat5.count",     32'(count5),     32'd3);
    check("sat5.out_valid", 32'(out_valid5), 32'd1);
    check("sat8.acc",       32'(acc8),       32'd34);
    check("sat8.ovf",       32'(ovf8),       32'd0);
    drive(0, 0, 0, 1, 1); tick();
    check("sat5.hs_acc", 32'(acc5), 32'd0);
    check("sat5.hs_ovf", 32'(ovf5), 32'd0);

    // Backpressure: DONE held five cycles while upstream keeps offering.
    drive(1, 2, 1, 0, 1); tick();
    for (int k = 0; k < 5; k++) begin
      drive(1, 9, 0, 0, 1);
      tick();
      check8($sformatf("hold%0d", k), 8'd2, 4'd1, 1'b0, 1'b1, 1'b0);
    end
    drive(0, 0, 0, 1, 1); tick();
    check8("hold_hs", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Enable dropped mid-frame, then again in DONE with out_ready high.
    drive(1, 4, 0, 0, 1); tick();
    drive(1, 4, 0, 0, 1); tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 4, 1, 1, 0);
      tick();
      check8($sformatf("frz%0d", k), 8'd8, 4'd2, 1'b0, 1'b0, 1'b0);
    end
    drive(1, 4, 1, 0, 1); tick();
    check8("frz_done", 8'd12, 4'd3, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      drive(0, 0, 0, 1, 0);
      tick();
      check8($sformatf("frzd%0d", k), 8'd12, 4'd3, 1'b0, 1'b1, 1'b0);
    end
    drive(0, 0, 0, 1, 1); tick();
    check8("frz_hs", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-frame discards the partial total.
    drive(1, 6, 0, 0, 1); tick();
    drive(1, 6, 0, 0, 1); tick();
    check("arst.pre_acc", 32'(acc8), 32'd12);
    drive(0, 0, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check8("arst", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    drive(1, 2, 0, 0, 1); tick();
    drive(1, 2, 1, 0, 1); tick();
    check8("post_rst", 8'd4, 4'd2, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 0, 1, 1); tick();
    check8("post_hs", 8'd0, 4'd0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_nibble_sum_accum
`default_nettype wire

// File: doc/nibble_sum_accum.md
NIBBLE_SUM_ACCUM -- requirements
Module: nibble_sum_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 8: accumulator width in bits, legal range 5..12.
REQ-002 SHALL have parameter MAX_CNT, default 15: maximum samples per frame, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ena, input, 1: global enable; when low, the block is frozen.
REQ-006 SHALL have port in_valid, input, 1: upstream 4-bit adder result is valid.
REQ-007 SHALL have port in_sum, input, 4: upstream nibble sum, unsigned.
REQ-008 SHALL have port in_last, input, 1: the current sample closes the frame.
REQ-009 SHALL have port in_ready, output, 1: block accepts a sample this cycle.
REQ-010 SHALL have port acc, output, ACC_W: accumulated frame total.
REQ-011 SHALL have port count, output, 4: number of samples in the frame.
REQ-012 SHALL have port ovf, output, 1: sticky saturation flag for the frame.
REQ-013 SHALL have port out_valid, output, 1: frame result is presented.
REQ-014 SHALL have port out_ready, input, 1: downstream consumes the result.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE; the reset state is IDLE.
REQ-016 SHALL drive in_ready = ena AND (state != DONE), combinationally.
REQ-017 SHALL treat a transfer as in_valid AND in_ready, sampled at the rising clk edge.
REQ-018 On an IDLE transfer, SHALL load acc with in_sum zero-extended, count with 1 and ovf with 0, then move to ACCUM (or to DONE if in_last or MAX_CNT=1).
REQ-019 On an ACCUM transfer, SHALL set acc to acc+in_sum saturating at 2^ACC_W-1, set ovf if saturation occurred (ovf is sticky), and increment count.
REQ-020 SHALL move ACCUM->DONE on the transfer where in_last=1 or where count reaches MAX_CNT, whichever occurs first.
REQ-021 SHALL assert out_valid exactly while in DONE, first in the cycle after the closing transfer (latency 1).
REQ-022 In DONE, SHALL hold acc, count and ovf stable until out_ready=1 with ena=1.
REQ-023 On handshake in DONE, SHALL clear acc, count and ovf to 0 and return to IDLE; out_valid drops in the next cycle.
REQ-024 SHALL NOT change any state or output register while ena=0, including in DONE with out_ready=1.
REQ-025 SHALL ignore in_last when in_valid=0.
REQ-026 SHALL leave state unchanged when in_valid=0 in IDLE or ACCUM (bubbles permitted).

Reset
REQ-027 SHALL asynchronously force state=IDLE, acc=0, count=0, ovf=0 and out_valid=0 when rst_n is low, including mid-frame; the partial frame is discarded.
REQ-028 SHALL resume normal operation on the first rising clk edge after rst_n is released.

Structure
REQ-029 SHALL place the state encoding (2-bit enum IDLE=0, ACCUM=1, DONE=2) and the constant NIB_W=4 in the shared package nibble_accum_pkg.
REQ-030 SHALL implement the saturating add as one sub-module, sat_add, taking ACC_W, a, b and returning sum and sat.

Verification
REQ-031 Bench SHALL send samples 3,5,7 with last on the third -> acc=15, count=3, ovf=0, out_valid=1 one cycle later; after out_ready -> IDLE with acc=0.
REQ-032 Bench SHALL send samples 15,1 (two samples, ACC_W=8 default, MAX_CNT=15) without in_last -> no DONE; then send 15 samples of 15 total -> count=15 forces DONE with acc=225, ovf=0.
REQ-033 Bench SHALL use ACC_W=5 and send 15,15,4 with last -> acc=31, ovf=1, count=3.
REQ-034 Bench SHALL hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, acc/count stable, out_valid stays 1.
REQ-035 Bench SHALL drop ena for 3 cycles mid-frame with in_valid=1 -> no count change; after ena returns, the frame completes with the correct total.
REQ-036 Bench SHALL assert rst_n=0 asynchronously after two samples -> all outputs 0 immediately; the next frame 2,2 with last -> acc=4, count=2.
